// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (A) and load (B) writeback,
// with one registered write stage bypassed onto both read ports.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [SEL_W-1:0]  a_sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [SEL_W-1:0]  b_sel,
    input  logic [DATA_W-1:0] b_data,
    input  logic              hold,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_sel0,
    input  logic [SEL_W-1:0]  rd_sel1,
    input  logic [DATA_W-1:0] rf_out0,
    input  logic [DATA_W-1:0] rf_out1,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t             prio;
    logic              grant_a;
    logic              grant_b;
    logic              grant;
    logic [SEL_W-1:0]  grant_sel;
    logic [DATA_W-1:0] grant_data;

    // Grant decode: a lone requester wins, contention is resolved by prio.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        grant_sel  = '0;
        grant_data = '0;
        if (rst_n && !hold) begin
            if (a_valid && (!b_valid || prio == PRIO_A)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            grant_sel  = a_sel;
            grant_data = a_data;
        end else if (grant_b) begin
            grant_sel  = b_sel;
            grant_data = b_data;
        end
    end

    assign grant   = grant_a | grant_b;
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Write stage; $zero writes complete the handshake but never raise wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
            prio    <= PRIO_A;
        end else if (grant) begin
            wr_en   <= (grant_sel != '0);
            wr_sel  <= grant_sel;
            wr_data <= grant_data;
            prio    <= grant_a ? PRIO_B : PRIO_A;
        end else begin
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
        end
    end

    // Forward the staged write so readers never see the pre-commit value.
    always_comb begin
        out0 = rf_out0;
        out1 = rf_out1;
        if (wr_en && rd_sel0 != '0 && wr_sel == rd_sel0) begin
            out0 = wr_data;
        end
        if (wr_en && rd_sel1 != '0 && wr_sel == rd_sel1) begin
            out1 = wr_data;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural regfile behind the write port.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid, hold;
    logic        a_ready, b_ready;
    logic [4:0]  a_sel, b_sel;
    logic [31:0] a_data, b_data;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  rd_sel0, rd_sel1;
    logic [31:0] rf_out0, rf_out1;
    logic [31:0] out0, out1;

    int passes = 0;
    int total  = 0;

    logic [31:0] regs [32];

    rf_wb_arbiter #(.DATA_W(32), .SEL_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_data(b_data),
        .hold(hold),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel0(rd_sel0), .rd_sel1(rd_sel1),
        .rf_out0(rf_out0), .rf_out1(rf_out1),
        .out0(out0), .out1(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: commits the staged write at the clock edge.
    always @(posedge clk) begin
        if (wr_en) regs[wr_sel] <= wr_data;
    end
    assign rf_out0 = regs[rd_sel0];
    assign rf_out1 = regs[rd_sel1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0;
        a_valid = 1'b1; a_sel = 5'd5; a_data = 32'h0000_00a5;
        b_valid = 1'b1; b_sel = 5'd6; b_data = 32'h0000_00b6;
        rd_sel0 = 5'd0; rd_sel1 = 5'd0;
        #2;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_sel", wr_sel, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        tick();
        rst_n = 1'b1;

        // Continuous contention: A, B, A, B with no gaps
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_a_ready", a_ready, (i % 2 == 0));
            chk("cont_b_ready", b_ready, (i % 2 == 1));
            tick();
            chk("cont_wr_en", wr_en, 1);
            chk("cont_wr_sel", wr_sel, (i % 2 == 0) ? 5 : 6);
            chk("cont_wr_data", wr_data, (i % 2 == 0) ? 32'ha5 : 32'hb6);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Single write from A
        a_valid = 1'b1; a_sel = 5'd3; a_data = 32'hafaf_afaf;
        #1;
        chk("single_a_ready", a_ready, 1);
        chk("single_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        chk("single_wr_en", wr_en, 1);
        chk("single_wr_sel", wr_sel, 3);
        chk("single_wr_data", wr_data, 32'hafaf_afaf);
        tick();
        chk("single_idle_en", wr_en, 0);
        chk("single_idle_sel", wr_sel, 0);

        // $zero write: accepted, dropped, prio flips back to A
        b_valid = 1'b1; b_sel = 5'd0; b_data = 32'h0101_0101;
        #1;
        chk("zero_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        chk("zero_wr_en", wr_en, 0);
        a_valid = 1'b1; a_sel = 5'd7; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_sel = 5'd7; b_data = 32'h2222_2222;
        #1;
        chk("zero_prio_a", a_ready, 1);
        chk("zero_prio_b", b_ready, 0);

        // Hold blocks grants and keeps prio
        hold = 1'b1;
        #1;
        chk("hold_a_ready", a_ready, 0);
        chk("hold_b_ready", b_ready, 0);
        tick();
        chk("hold_wr_en", wr_en, 0);
        tick();
        hold = 1'b0;
        #1;
        chk("unhold_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        chk("same_first_sel", wr_sel, 7);
        chk("same_first_data", wr_data, 32'h1111_1111);
        #1;
        chk("same_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        rd_sel0 = 5'd7;
        #1;
        chk("same_second_en", wr_en, 1);
        chk("same_second_data", wr_data, 32'h2222_2222);
        chk("same_bypass", out0, 32'h2222_2222);
        tick();
        chk("same_final_reg", out0, 32'h2222_2222);

        // Bypass: reg1 holds afafafaf, staged 01010101 must win on both ports
        a_valid = 1'b1; a_sel = 5'd1; a_data = 32'hafaf_afaf;
        tick();
        a_data = 32'h0101_0101;
        tick();
        a_valid = 1'b0;
        rd_sel0 = 5'd1; rd_sel1 = 5'd1;
        #1;
        chk("byp_rf_old", rf_out0, 32'hafaf_afaf);
        chk("byp_out0", out0, 32'h0101_0101);
        chk("byp_out1", out1, 32'h0101_0101);
        tick();
        chk("byp_commit0", out0, 32'h0101_0101);
        chk("byp_commit1", out1, 32'h0101_0101);
        rd_sel1 = 5'd3;
        #1;
        chk("byp_other_reg", out1, 32'hafaf_afaf);

        // Reset mid-operation discards the staged write immediately
        a_valid = 1'b1; a_sel = 5'd9; a_data = 32'h9999_9999;
        tick();
        a_valid = 1'b0;
        chk("midrst_staged", wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_data", wr_data, 0);
        tick();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
